// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit core: opcode constants, link register and WB latch layout.
package wisc_pkg;

    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_ORI   = 5'b01010;
    localparam logic [4:0] OP_ANDI  = 5'b01011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRAI  = 5'b10111;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_RTYPE = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;

    localparam logic [2:0] REG_LINK = 3'd7;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_entry_t;

endpackage

// File: rtl/dest_reg_decode.sv
// Combinational destination-register decode from an instruction word; shared with the hazard unit.
module dest_reg_decode
    import wisc_pkg::*;
(
    input  logic [15:0] in_instr,
    output logic        dec_we,
    output logic [2:0]  dec_rd
);

    logic [4:0] w_op5;
    logic       w_unused;

    assign w_op5    = in_instr[15:11];
    assign w_unused = ^in_instr[1:0];

    // Select the destination field by instruction format; non-writing opcodes fall to default.
    always_comb begin
        dec_we = 1'b0;
        dec_rd = 3'd0;
        case (w_op5)
            OP_RTYPE, OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_BTR: begin
                dec_we = 1'b1;
                dec_rd = in_instr[4:2];
            end
            OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRAI, OP_LD: begin
                dec_we = 1'b1;
                dec_rd = in_instr[7:5];
            end
            OP_LBI, OP_SLBI: begin
                dec_we = 1'b1;
                dec_rd = in_instr[10:8];
            end
            OP_JAL, OP_JALR: begin
                dec_we = 1'b1;
                dec_rd = REG_LINK;
            end
            default: begin
                dec_we = 1'b0;
                dec_rd = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage latch plus 8x16 architectural register file with two bypassed read ports.
module wb_regfile
    import wisc_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          stall,
    input  logic          flush,
    input  logic [15:0]   in_instr,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    rs_addr,
    input  logic [2:0]    rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic          wb_we,
    output logic [2:0]    wb_rd
);

    wb_entry_t     r_wb;
    logic [DW-1:0] r_regs [NREG];
    logic          w_dec_we;
    logic [2:0]    w_dec_rd;
    logic          w_accept;
    logic          w_commit;
    logic          w_byp_rs;
    logic          w_byp_rt;

    dest_reg_decode u_dest_reg_decode (
        .in_instr (in_instr),
        .dec_we   (w_dec_we),
        .dec_rd   (w_dec_rd)
    );

    assign in_ready = ~stall;
    assign w_accept = in_valid & ~stall & ~flush;
    assign w_commit = r_wb.valid & r_wb.we & ~flush;
    assign wb_we    = r_wb.valid & r_wb.we;
    assign wb_rd    = r_wb.rd;

    // WB latch: flush squashes, otherwise load on accept or drain to invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb <= '0;
        end else if (flush) begin
            r_wb.valid <= 1'b0;
            r_wb.we    <= 1'b0;
        end else if (w_accept) begin
            r_wb.valid <= 1'b1;
            r_wb.we    <= w_dec_we;
            r_wb.rd    <= w_dec_rd;
            r_wb.data  <= in_data;
        end else begin
            r_wb.valid <= 1'b0;
        end
    end

    // Architectural commit; stall does not block it because the latch drains the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_wb.rd] <= r_wb.data;
        end else begin
            r_regs <= r_regs;
        end
    end

    assign w_byp_rs = w_commit & (r_wb.rd == rs_addr);
    assign w_byp_rt = w_commit & (r_wb.rd == rt_addr);

    // Read ports forward the pending entry so decode sees it one cycle early.
    always_comb begin
        if (w_byp_rs) begin
            rs_data = r_wb.data;
        end else begin
            rs_data = r_regs[rs_addr];
        end
        if (w_byp_rt) begin
            rt_data = r_wb.data;
        end else begin
            rt_data = r_regs[rt_addr];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: bypass, commit latency, flush, stall and reset.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic [15:0] in_instr;
    logic [15:0] in_data;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        wb_we;
    logic [2:0]  wb_rd;

    int n_cmp;
    int n_bad;

    wb_regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .stall    (stall),
        .flush    (flush),
        .in_instr (in_instr),
        .in_data  (in_data),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        in_instr = 16'h0000; in_data = 16'h0000; rs_addr = 3'd0; rt_addr = 3'd0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        for (int a = 0; a < 8; a++) begin
            rs_addr = a[2:0]; rt_addr = 3'(7 - a);
            #1;
            n_cmp++;
            if (rs_data !== 16'h0000 || rt_data !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_read a=%0d rs=%h rt=%h want 0000", a, rs_data, rt_data);
            end
        end
        n_cmp++;
        if (wb_we !== 1'b0 || wb_rd !== 3'd0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_wb we=%b rd=%0d rdy=%b want 0 0 1", wb_we, wb_rd, in_ready);
        end
    endtask

    task automatic test_add_bypass();
        in_valid = 1'b1; in_instr = 16'hD86C; in_data = 16'h1234;
        rs_addr = 3'd3; rt_addr = 3'd4;
        tick();
        in_valid = 1'b0; in_data = 16'h0000;
        n_cmp++;
        if (wb_we !== 1'b1 || wb_rd !== 3'd3) begin
            n_bad++;
            $display("FAIL add_pending we=%b rd=%0d want 1 3", wb_we, wb_rd);
        end
        n_cmp++;
        if (rs_data !== 16'h1234 || rt_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL add_bypass rs=%h rt=%h want 1234 0000", rs_data, rt_data);
        end
        tick();
        n_cmp++;
        if (rs_data !== 16'h1234 || wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL add_commit rs=%h we=%b want 1234 0", rs_data, wb_we);
        end
    endtask

    task automatic test_jal_then_store();
        in_valid = 1'b1; in_instr = 16'h3000; in_data = 16'h0042; rs_addr = 3'd7;
        tick();
        in_instr = 16'h8000; in_data = 16'hDEAD;
        tick();
        n_cmp++;
        if (rs_data !== 16'h0042) begin
            n_bad++;
            $display("FAIL jal_r7 got %h want 0042", rs_data);
        end
        n_cmp++;
        if (wb_we !== 1'b0 || wb_rd !== 3'd0) begin
            n_bad++;
            $display("FAIL st_no_we we=%b rd=%0d want 0 0", wb_we, wb_rd);
        end
        in_valid = 1'b0;
        tick();
        for (int a = 0; a < 8; a++) begin
            rs_addr = a[2:0];
            #1;
            n_cmp++;
            if (rs_data !== (a == 3 ? 16'h1234 : (a == 7 ? 16'h0042 : 16'h0000))) begin
                n_bad++;
                $display("FAIL st_regs a=%0d got %h", a, rs_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = 16'hC1FF; in_data = 16'h00FF; rs_addr = 3'd1;
        tick();
        in_instr = 16'h4020; in_data = 16'h0100;
        n_cmp++;
        if (rs_data !== 16'h00FF) begin
            n_bad++;
            $display("FAIL b2b_first got %h want 00ff", rs_data);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (rs_data !== 16'h0100 || wb_rd !== 3'd1 || wb_we !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second rs=%h rd=%0d we=%b want 0100 1 1", rs_data, wb_rd, wb_we);
        end
        tick();
        n_cmp++;
        if (rs_data !== 16'h0100 || wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_final rs=%h we=%b want 0100 0", rs_data, wb_we);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = 16'h88A0; in_data = 16'hBEEF;
        rs_addr = 3'd5; rt_addr = 3'd1;
        tick();
        flush = 1'b1; in_instr = 16'h4020; in_data = 16'h7777;
        #1;
        n_cmp++;
        if (rs_data !== 16'h0000 || wb_we !== 1'b1 || wb_rd !== 3'd5) begin
            n_bad++;
            $display("FAIL flush_cycle rs=%h we=%b rd=%0d want 0000 1 5", rs_data, wb_we, wb_rd);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (rs_data !== 16'h0000 || wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_after rs=%h we=%b want 0000 0", rs_data, wb_we);
        end
        tick();
        n_cmp++;
        if (rs_data !== 16'h0000 || rt_data !== 16'h0100) begin
            n_bad++;
            $display("FAIL flush_regs r5=%h r1=%h want 0000 0100", rs_data, rt_data);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; in_valid = 1'b1; in_instr = 16'h9200; in_data = 16'h5A5A; rs_addr = 3'd2;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_ready got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (wb_we !== 1'b0 || rs_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL stall_hold we=%b r2=%h want 0 0000", wb_we, rs_data);
        end
        stall = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL unstall_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (wb_we !== 1'b1 || wb_rd !== 3'd2) begin
            n_bad++;
            $display("FAIL unstall_accept we=%b rd=%0d want 1 2", wb_we, wb_rd);
        end
        tick();
        n_cmp++;
        if (rs_data !== 16'h5A5A) begin
            n_bad++;
            $display("FAIL unstall_commit r2=%h want 5a5a", rs_data);
        end
        // A pending entry must still commit when stall rises behind it, exactly once.
        in_valid = 1'b1; in_instr = 16'h4020; in_data = 16'h2222; rs_addr = 3'd1;
        tick();
        stall = 1'b1; in_instr = 16'hC1FF; in_data = 16'h9999;
        tick();
        n_cmp++;
        if (rs_data !== 16'h2222 || wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_drain r1=%h we=%b want 2222 0", rs_data, wb_we);
        end
        stall = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset_midop();
        in_valid = 1'b1; in_instr = 16'h3000; in_data = 16'hABCD; rs_addr = 3'd7; rt_addr = 3'd2;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rs_data !== 16'h0000 || rt_data !== 16'h0000 || wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midop r7=%h r2=%h we=%b want 0000 0000 0", rs_data, rt_data, wb_we);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (rs_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_drop r7=%h want 0000", rs_data);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add_bypass();
        test_jal_then_store();
        test_back_to_back();
        test_flush();
        test_stall();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
